// File: rtl/registre_piso_pkg.sv
// Shared definitions for the parallel-in/serial-out shifter: default word width
// and the two-state shifter encoding.
package registre_piso_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic {
    SHIFT_IDLE = 1'b0,
    SHIFT_RUN  = 1'b1
  } shift_state_e;

endpackage

// File: rtl/registre_piso_bascule_d_rst.sv
// One storage bit of the shifter: D flip-flop, async active-high reset to 0,
// true and complemented outputs.
module bascule_d_rst (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic qbar_o
);

  logic q_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) q_q <= 1'b0;
    else       q_q <= d_i;
  end

  assign q_o    = q_q;
  assign qbar_o = ~q_q;

endmodule

// File: rtl/registre_piso.sv
// Parallel-in/serial-out register: accepts a WIDTH-bit word when idle, shifts it
// out LSB first over WIDTH cycles, then pulses done for one cycle (WIDTH+1 per word).
module registre_piso
  import registre_piso_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             s1,
  output logic             s2,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  shift_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sr_d, sr_q, sr_qbar;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SHIFT_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    sr_d    = sr_q;
    case (state_q)
      SHIFT_IDLE: begin
        if (in_valid) begin
          state_d = SHIFT_RUN;
          cnt_d   = CNT_W'(WIDTH - 1);
          sr_d    = in_data;
        end
      end
      SHIFT_RUN: begin
        if (cnt_q == '0) begin
          state_d = SHIFT_IDLE;
          done_d  = 1'b1;
          sr_d    = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          // Shift right; upper bits come from the complemented flop outputs.
          sr_d  = {1'b0, ~sr_qbar[WIDTH-1:1]};
        end
      end
      default: state_d = SHIFT_IDLE;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    bascule_d_rst u_bit (
      .clk_i  (clk),
      .rst_i  (rst),
      .d_i    (sr_d[i]),
      .q_o    (sr_q[i]),
      .qbar_o (sr_qbar[i])
    );
  end

  assign in_ready = (state_q == SHIFT_IDLE);
  assign busy     = ~in_ready;
  assign s1       = busy & sr_q[0];
  assign s2       = in_ready | sr_qbar[0];
  assign done     = done_q;

endmodule

// File: doc/registre_piso.md
REGISTRE_PISO -- requirements
Module: registre_piso

Interface
REQ-001 Parameter WIDTH, default 8, number of bits per parallel word; legal range 2..32.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port in_valid  input  1  in_data holds a word offered for serialisation.
REQ-005 Port in_ready  output  1  block can accept a word this cycle.
REQ-006 Port in_data  input  WIDTH  parallel word; sampled only on accept.
REQ-007 Port s1  output  1  serial data out, LSB first.
REQ-008 Port s2  output  1  complement of s1.
REQ-009 Port busy  output  1  high while a word is being shifted out.
REQ-010 Port done  output  1  one-cycle pulse after the last bit of a word.

Function
REQ-011 States SHIFT_IDLE and SHIFT_RUN; the block SHALL be in exactly one at all times.
REQ-012 in_ready SHALL equal (state == SHIFT_IDLE), combinationally; busy SHALL equal its inverse.
REQ-013 Accept = in_valid && in_ready at a rising edge; on accept: shift register <= in_data, bit counter <= WIDTH-1, state <= SHIFT_RUN.
REQ-014 In SHIFT_RUN, s1 SHALL equal shift register bit 0, so bit k of the accepted word is on s1 during the k-th cycle after the accept edge (k = 0..WIDTH-1).
REQ-015 Each rising edge in SHIFT_RUN with counter != 0: shift register shifts right by one (MSB filled with 0), counter decrements by 1.
REQ-016 Rising edge in SHIFT_RUN with counter == 0: state <= SHIFT_IDLE, done <= 1; done SHALL be 0 at every other edge.
REQ-017 In SHIFT_IDLE, s1 SHALL be 0.
REQ-018 s2 SHALL equal ~s1 at all times, including during and after reset.
REQ-019 A word occupies exactly WIDTH cycles of SHIFT_RUN; earliest next accept is the edge ending the done cycle, giving WIDTH+1 cycles per word back-to-back.
REQ-020 in_valid and in_data changes during SHIFT_RUN SHALL be ignored; no buffering of a second word.
REQ-021 Counter width SHALL be clog2(WIDTH); counter SHALL never wrap below 0.

Reset
REQ-022 While rst is high, asynchronously: state = SHIFT_IDLE, shift register = 0, counter = 0, done = 0, so s1 = 0, s2 = 1, in_ready = 1, busy = 0.
REQ-023 Reset asserted mid-word SHALL abort the word immediately with no done pulse; the first accept is allowed at the first rising edge after rst falls.

Structure
REQ-024 State encodings (SHIFT_IDLE = 0, SHIFT_RUN = 1) and the default WIDTH SHALL live in the shared memory package/include used by the memory library.
REQ-025 Storage SHALL be built from WIDTH instances of sub-module bascule_d_rst (1-bit D flip-flop with async active-high reset, outputs Q and Qbar); control logic stays in registre_piso.

Verification
REQ-026 Reset: rst=1 at t=0 with in_valid=1 -> s1=0, s2=1, in_ready=1, busy=0, done=0 throughout reset.
REQ-027 Single word: WIDTH=8, in_data=8'hA5 accepted -> s1 over next 8 cycles = 1,0,1,0,0,1,0,1; s2 inverse; done high on 9th cycle only.
REQ-028 Back-to-back: in_valid held high, words 8'h01 then 8'hFF -> second accept exactly 9 cycles after first; s1 = 1,0,0,0,0,0,0,0, 0 (done cycle), then eight 1s.
REQ-029 Ignore-while-busy: change in_data to 8'h00 and pulse in_valid mid-word of 8'hF0 -> serial stream still 0,0,0,0,1,1,1,1; in_ready stays 0.
REQ-030 Reset mid-word: rst pulse after 3 bits of 8'hFF -> s1=0 immediately, no done pulse, next word 8'h03 serialises as 1,1,0,0,0,0,0,0.
REQ-031 Width boundary: WIDTH=2, in_data=2'b10 -> s1 = 0,1, done on 3rd cycle, counter never below 0.
